// File: rtl/seq_det_sched_if.sv
// seq_det_sched_if: requester-side bus of the shared detector scheduler.
// master = byte producers, slave = scheduler.
interface seq_det_sched_if #(
  parameter int DW  = 8,
  parameter int HCW = 4
) ();
  logic           REQ_A;
  logic [DW-1:0]  DATA_A;
  logic           REQ_B;
  logic [DW-1:0]  DATA_B;
  logic           ACK_A;
  logic           ACK_B;
  logic [HCW-1:0] HIT_CNT;
  logic           BUSY;

  modport master (
    output REQ_A, DATA_A, REQ_B, DATA_B,
    input  ACK_A, ACK_B, HIT_CNT, BUSY
  );

  modport slave (
    input  REQ_A, DATA_A, REQ_B, DATA_B,
    output ACK_A, ACK_B, HIT_CNT, BUSY
  );
endinterface

// File: rtl/seq_det_sched.sv
// seq_det_sched: shares one serial pattern detector between requesters A/B.
// Round-robin; SEQ_SCHED_FIXED_PRIO_EN makes A always win instead.
module seq_det_sched #(
  parameter int DW  = 8,
  parameter int HCW = 4
) (
  input  logic           CLK,
  input  logic           RET,
  seq_det_sched_if.slave bus,
  output logic           DET_DATA,
  output logic           DET_RST,
  input  logic           DET_OUT
);
  localparam int BCW = $clog2(DW);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    DRAIN,
    DONE
  } state_e;

  state_e         state_q, state_d;
  logic [DW-1:0]  sreg_q, sreg_d;
  logic [BCW-1:0] bcnt_q, bcnt_d;
  logic [HCW-1:0] hcnt_q, hcnt_d;
  logic           gnt_q, gnt_d;
  logic           ack_a_q, ack_a_d;
  logic           ack_b_q, ack_b_d;
  logic [HCW-1:0] hit_q, hit_d;
  logic           busy_q, busy_d;
  logic           ddat_q, ddat_d;
  logic           drst_q, drst_d;

  logic           pick_b;
  logic [DW-1:0]  pick_data;
  logic [HCW-1:0] hit_nx;

`ifdef SEQ_SCHED_FIXED_PRIO_EN
  assign pick_b = ~bus.REQ_A;
`else
  logic rr_q, rr_d;

  // rr_q=1 means B is preferred on the next tie
  assign pick_b = bus.REQ_B & (~bus.REQ_A | rr_q);
  assign rr_d   = (state_q == DONE) ? ~gnt_q : rr_q;

  // round-robin pointer, A preferred out of reset
  always_ff @(posedge CLK or negedge RET) begin
    if (!RET) rr_q <= 1'b0;
    else      rr_q <= rr_d;
  end
`endif

  assign pick_data = pick_b ? bus.DATA_B : bus.DATA_A;

  assign hit_nx = (DET_OUT && (hcnt_q != '1))
                ? hcnt_q + HCW'(1)
                : hcnt_q;

  // next-state and registered-output decode
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    bcnt_d  = bcnt_q;
    hcnt_d  = hcnt_q;
    gnt_d   = gnt_q;
    ack_a_d = 1'b0;
    ack_b_d = 1'b0;
    hit_d   = hit_q;
    ddat_d  = ddat_q;
    drst_d  = drst_q;
    unique case (state_q)
      IDLE: begin
        drst_d = 1'b1;
        ddat_d = 1'b0;
        if (bus.REQ_A || bus.REQ_B) begin
          state_d = LOAD;
          gnt_d   = pick_b;
          ddat_d  = pick_data[DW-1];
          sreg_d  = {pick_data[DW-2:0], 1'b0};
          drst_d  = 1'b0;
          bcnt_d  = '0;
          hcnt_d  = '0;
        end
      end
      LOAD: begin
        state_d = SHIFT;
        ddat_d  = sreg_q[DW-1];
        sreg_d  = {sreg_q[DW-2:0], 1'b0};
      end
      SHIFT: begin
        hcnt_d = hit_nx;
        bcnt_d = bcnt_q + BCW'(1);
        ddat_d = sreg_q[DW-1];
        sreg_d = {sreg_q[DW-2:0], 1'b0};
        if (bcnt_q == BCW'(DW - 1)) begin
          state_d = DRAIN;
          ddat_d  = 1'b0;
        end
      end
      DRAIN: begin
        state_d = DONE;
        hcnt_d  = hit_nx;
        hit_d   = hit_nx;
        ack_a_d = ~gnt_q;
        ack_b_d = gnt_q;
        drst_d  = 1'b1;
        ddat_d  = 1'b0;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        drst_d  = 1'b1;
        ddat_d  = 1'b0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // state and output registers
  always_ff @(posedge CLK or negedge RET) begin
    if (!RET) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      bcnt_q  <= '0;
      hcnt_q  <= '0;
      gnt_q   <= 1'b0;
      ack_a_q <= 1'b0;
      ack_b_q <= 1'b0;
      hit_q   <= '0;
      busy_q  <= 1'b0;
      ddat_q  <= 1'b0;
      drst_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      bcnt_q  <= bcnt_d;
      hcnt_q  <= hcnt_d;
      gnt_q   <= gnt_d;
      ack_a_q <= ack_a_d;
      ack_b_q <= ack_b_d;
      hit_q   <= hit_d;
      busy_q  <= busy_d;
      ddat_q  <= ddat_d;
      drst_q  <= drst_d;
    end
  end

  assign bus.ACK_A   = ack_a_q;
  assign bus.ACK_B   = ack_b_q;
  assign bus.HIT_CNT = hit_q;
  assign bus.BUSY    = busy_q;
  assign DET_DATA    = ddat_q;
  assign DET_RST     = drst_q;
endmodule

// File: tb/tb_seq_det_sched.sv
// tb_seq_det_sched: vector table, directed corner sequences and a
// randomized run against a transaction-level scheduler model.
`timescale 1ns/1ps
module tb_seq_det_sched;
  localparam int DW  = 8;
  localparam int HCW = 4;
`ifdef SEQ_SCHED_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic det_data, det_rst, det_out;
  int   n_chk  = 0;
  int   n_fail = 0;

  seq_det_sched_if #(.DW(DW), .HCW(HCW)) bus ();

  seq_det_sched #(.DW(DW), .HCW(HCW)) dut (
    .CLK      (clk),
    .RET      (rst_n),
    .bus      (bus),
    .DET_DATA (det_data),
    .DET_RST  (det_rst),
    .DET_OUT  (det_out)
  );

  always #5 clk = ~clk;

  // "1011" detector: input register, then FSM; idle again after a hit
  logic       d_in  = 1'b0;
  logic       d_inv = 1'b0;
  logic       d_out = 1'b0;
  logic [3:0] d_hist = 4'd0;
  int         d_n = 0;
  always @(posedge clk) begin
    logic [3:0] hn;
    int nn;
    if (det_rst) begin
      d_in <= 1'b0; d_inv <= 1'b0; d_out <= 1'b0;
      d_hist <= 4'd0; d_n <= 0;
    end else begin
      d_in  <= det_data;
      d_inv <= 1'b1;
      d_out <= 1'b0;
      if (d_inv) begin
        hn = {d_hist[2:0], d_in};
        nn = d_n + 1;
        d_hist <= hn;
        if (nn >= 4 && hn == 4'b1011) begin
          d_out <= 1'b1;
          d_n   <= 0;
        end else begin
          d_n <= nn;
        end
      end
    end
  end
  assign det_out = d_out;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // non-overlapping "1011" occurrences in the byte, MSB first
  function automatic logic [HCW-1:0] ref_hits(input logic [DW-1:0] d);
    int h = 0;
    int run = 0;
    logic [3:0] w = 4'd0;
    for (int i = DW - 1; i >= 0; i--) begin
      w = {w[2:0], d[i]};
      run++;
      if (run >= 4 && w == 4'b1011) begin
        h++;
        run = 0;
      end
    end
    if (h > (2**HCW) - 1) h = (2**HCW) - 1;
    return HCW'(h);
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    bus.REQ_A = 1'b0; bus.REQ_B = 1'b0;
    bus.DATA_A = '0;  bus.DATA_B = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_ack(output int k);
    k = -1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.ACK_A || bus.ACK_B) begin
        k = i;
        break;
      end
    end
  endtask

  typedef struct {
    logic           ra;
    logic           rb;
    logic [DW-1:0]  da;
    logic [DW-1:0]  db;
    logic           exp_b;
    logic [HCW-1:0] exp_hit;
  } vec_t;

  vec_t tbl[8];
  int   k, nack, last, c;
  logic [DW-1:0] pat;
  int   t, free_e, ack_e, g0;
  logic m_side, m_next, pa, pb;
  logic [HCW-1:0] m_hit, m_pend;

  initial begin
    tbl[0] = '{1'b1, 1'b0, 8'hB0, 8'h00, 1'b0, 4'd1};
    tbl[1] = '{1'b0, 1'b1, 8'h00, 8'h00, 1'b1, 4'd0};
    tbl[2] = '{1'b1, 1'b1, 8'h0B, 8'hB0, 1'b0, 4'd1};
    tbl[3] = '{1'b1, 1'b1, 8'hFF, 8'hB6, !FIXED, FIXED ? 4'd0 : 4'd1};
    tbl[4] = '{1'b1, 1'b1, 8'h2D, 8'hB0, 1'b0, 4'd1};
    tbl[5] = '{1'b1, 1'b0, 8'hDD, 8'h00, 1'b0, 4'd1};
    tbl[6] = '{1'b0, 1'b1, 8'h00, 8'hBB, 1'b1, 4'd2};
    tbl[7] = '{1'b1, 1'b0, 8'h00, 8'hFF, 1'b0, 4'd0};

    #1;
    do_reset();
    @(posedge clk); #1;
    chk("rst_ack_a", 32'(bus.ACK_A), 0);
    chk("rst_ack_b", 32'(bus.ACK_B), 0);
    chk("rst_hit", 32'(bus.HIT_CNT), 0);
    chk("rst_busy", 32'(bus.BUSY), 0);
    chk("rst_ddata", 32'(det_data), 0);
    chk("rst_drst", 32'(det_rst), 1);

    foreach (tbl[i]) begin
      @(negedge clk);
      bus.REQ_A = tbl[i].ra; bus.DATA_A = tbl[i].da;
      bus.REQ_B = tbl[i].rb; bus.DATA_B = tbl[i].db;
      wait_ack(k);
      chk($sformatf("tbl%0d_lat", i), 32'(k), 32'(DW + 2));
      chk($sformatf("tbl%0d_ack_a", i), 32'(bus.ACK_A), 32'(!tbl[i].exp_b));
      chk($sformatf("tbl%0d_ack_b", i), 32'(bus.ACK_B), 32'(tbl[i].exp_b));
      chk($sformatf("tbl%0d_hit", i), 32'(bus.HIT_CNT), 32'(tbl[i].exp_hit));
      @(negedge clk);
      bus.REQ_A = 1'b0; bus.REQ_B = 1'b0;
      repeat (2) @(posedge clk); #1;
      chk($sformatf("tbl%0d_idle", i), 32'(bus.BUSY), 0);
      chk($sformatf("tbl%0d_hold", i), 32'(bus.HIT_CNT), 32'(tbl[i].exp_hit));
    end

    // one-cycle REQ_A pulse: full transaction, bit order, DET_RST window
    do_reset();
    pat = 8'hB0;
    @(negedge clk);
    bus.REQ_A = 1'b1; bus.DATA_A = pat;
    nack = 0;
    for (int j = 0; j < DW + 16; j++) begin
      @(posedge clk); #1;
      if (j == 0) bus.REQ_A = 1'b0;
      c = j + 1;
      if (bus.ACK_A) nack++;
      chk($sformatf("pulse_drst_c%0d", c), 32'(det_rst),
          32'((c >= 1 && c <= DW + 2) ? 0 : 1));
      chk($sformatf("pulse_busy_c%0d", c), 32'(bus.BUSY),
          32'((c <= DW + 3) ? 1 : 0));
      chk($sformatf("pulse_ack_a_c%0d", c), 32'(bus.ACK_A),
          32'((c == DW + 3) ? 1 : 0));
      chk($sformatf("pulse_ack_b_c%0d", c), 32'(bus.ACK_B), 0);
      if (c <= DW)
        chk($sformatf("pulse_ddata_c%0d", c), 32'(det_data), 32'(pat[DW-c]));
      if (c == DW + 2)
        chk("pulse_ddata_drain", 32'(det_data), 0);
      if (c == DW + 3)
        chk("pulse_hit", 32'(bus.HIT_CNT), 1);
    end
    chk("pulse_nack", 32'(nack), 1);

    // both held: alternation (or A starvation of B) and spacing
    do_reset();
    @(negedge clk);
    bus.REQ_A = 1'b1; bus.DATA_A = 8'hB0;
    bus.REQ_B = 1'b1; bus.DATA_B = 8'hB0;
    nack = 0;
    last = -1;
    for (int j = 0; j < 4 * (DW + 4) + 6; j++) begin
      @(posedge clk); #1;
      if (bus.ACK_A || bus.ACK_B) begin
        chk($sformatf("b2b%0d_ack_b", nack), 32'(bus.ACK_B),
            32'(FIXED ? 0 : nack % 2));
        chk($sformatf("b2b%0d_ack_a", nack), 32'(bus.ACK_A),
            32'(FIXED ? 1 : 1 - nack % 2));
        chk($sformatf("b2b%0d_gap", nack), 32'(j - last),
            32'((last < 0) ? DW + 3 : DW + 4));
        chk($sformatf("b2b%0d_hit", nack), 32'(bus.HIT_CNT), 1);
        last = j;
        nack++;
      end
    end
    chk("b2b_count", 32'(nack), 4);
    @(negedge clk);
    bus.REQ_A = 1'b0; bus.REQ_B = 1'b0;
    repeat (DW + 8) @(posedge clk);

    // asynchronous reset in the middle of a shift
    @(negedge clk);
    bus.REQ_A = 1'b1; bus.DATA_A = 8'hFF;
    repeat (5) @(posedge clk);
    #2;
    chk("arst_busy_pre", 32'(bus.BUSY), 1);
    rst_n = 1'b0;
    #1;
    chk("arst_ack_a", 32'(bus.ACK_A), 0);
    chk("arst_ack_b", 32'(bus.ACK_B), 0);
    chk("arst_busy", 32'(bus.BUSY), 0);
    chk("arst_drst", 32'(det_rst), 1);
    chk("arst_hit", 32'(bus.HIT_CNT), 0);
    bus.REQ_A = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    nack = 0;
    for (int j = 0; j < 3 * DW; j++) begin
      @(posedge clk); #1;
      if (bus.ACK_A || bus.ACK_B) nack++;
    end
    chk("arst_no_ack", 32'(nack), 0);
    chk("arst_idle", 32'(bus.BUSY), 0);

    // randomized requesters against a transaction-level model
    do_reset();
    free_e = 0; ack_e = -100; g0 = -100;
    m_side = 1'b0; m_next = 1'b0; m_hit = '0; m_pend = '0;
    pa = 1'b0; pb = 1'b0;
    for (t = 0; t < 900; t++) begin
      @(negedge clk);
      if (bus.ACK_A) begin bus.REQ_A = 1'b0; pa = 1'b0; end
      if (bus.ACK_B) begin bus.REQ_B = 1'b0; pb = 1'b0; end
      if (!pa && $urandom_range(3) == 0) begin
        bus.REQ_A = 1'b1; bus.DATA_A = DW'($urandom); pa = 1'b1;
      end
      if (!pb && $urandom_range(3) == 0) begin
        bus.REQ_B = 1'b1; bus.DATA_B = DW'($urandom); pb = 1'b1;
      end
      if (t >= free_e && (bus.REQ_A || bus.REQ_B)) begin
        if (bus.REQ_A && bus.REQ_B)
          m_side = FIXED ? 1'b0 : m_next;
        else
          m_side = bus.REQ_B;
        m_next = !m_side;
        m_pend = ref_hits(m_side ? bus.DATA_B : bus.DATA_A);
        g0     = t;
        ack_e  = t + DW + 2;
        free_e = t + DW + 4;
      end
      @(posedge clk); #1;
      if (t == ack_e) m_hit = m_pend;
      chk("rnd_ack_a", 32'(bus.ACK_A), 32'(t == ack_e && !m_side));
      chk("rnd_ack_b", 32'(bus.ACK_B), 32'(t == ack_e && m_side));
      chk("rnd_busy", 32'(bus.BUSY), 32'(t >= g0 && t <= g0 + DW + 2));
      chk("rnd_hit", 32'(bus.HIT_CNT), 32'(m_hit));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
